branch_resolve_unit: RTL and testbench

- Execute-stage branch resolution block. It sits directly downstream of the branch comparator and also drives that comparator's unsigned-select input.
- It turns the comparator's less and equal flags, plus the decoded funct3 and jump type, into a taken decision and a jump target.
- It issues a registered PC redirect to the fetch stage, then sequences a multi-cycle flush of the younger pipeline stages.
- It keeps saturating counters of conditional branches and taken branches.

---
 rtl/branch_resolve_unit.sv | 161 ++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: decodes the comparator flags into a
// taken decision, computes the jump target, issues a registered redirect to
// fetch, sequences a multi-cycle flush of the younger stages and keeps
// saturating conditional/taken branch counters.
module branch_resolve_unit #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            stall_i,
    input  logic            ex_valid_i,
    input  logic            ex_is_br_i,
    input  logic            ex_is_jal_i,
    input  logic            ex_is_jalr_i,
    input  logic [2:0]      ex_funct3_i,
    input  logic [XLEN-1:0] ex_pc_i,
    input  logic [XLEN-1:0] ex_imm_i,
    input  logic [XLEN-1:0] ex_rs1_data_i,
    input  logic            br_less_i,
    input  logic            br_equal_i,
    output logic            br_unsigned_o,
    output logic            redirect_o,
    output logic [XLEN-1:0] pc_target_o,
    output logic            flush_o,
    output logic            misalign_o,
    output logic            illegal_br_o,
    output logic [CNT_W-1:0] br_count_o,
    output logic [CNT_W-1:0] taken_count_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // Flush counter is 4 bits wide, enough for the 1..15 cycle range.
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

    state_t            state_reg;
    logic [3:0]        flush_cnt_reg;
    logic              redirect_reg;
    logic              misalign_reg;
    logic              illegal_reg;
    logic [XLEN-1:0]   target_reg;
    logic [CNT_W-1:0]  br_cnt_reg;
    logic [CNT_W-1:0]  taken_cnt_reg;

    logic              sel_jalr;
    logic              sel_jal;
    logic              sel_br;
    logic              br_illegal;
    logic              cond_taken;
    logic              taken;
    logic [XLEN-1:0]   sum_pc;
    logic [XLEN-1:0]   sum_rs1;
    logic [XLEN-1:0]   target_next;
    logic              misaligned;
    logic              resolve;
    logic              do_redirect;
    logic              do_misalign;
    logic              count_br;
    logic              count_taken;

    // The comparator only needs funct3[1] to pick signed vs unsigned compare.
    assign br_unsigned_o = ex_funct3_i[1];

    // JALR wins over JAL, which wins over a conditional branch.
    assign sel_jalr   = ex_is_jalr_i;
    assign sel_jal    = ex_is_jal_i & ~ex_is_jalr_i;
    assign sel_br     = ex_is_br_i & ~ex_is_jal_i & ~ex_is_jalr_i;
    assign br_illegal = sel_br & (ex_funct3_i[2:1] == 2'b01);

    // Conditional-branch outcome from funct3 and the comparator flags.
    always_comb begin
        cond_taken = 1'b0;
        case (ex_funct3_i)
            3'b000:  cond_taken = br_equal_i;
            3'b001:  cond_taken = ~br_equal_i;
            3'b100:  cond_taken = br_less_i;
            3'b101:  cond_taken = ~br_less_i;
            3'b110:  cond_taken = br_less_i;
            3'b111:  cond_taken = ~br_less_i;
            default: cond_taken = 1'b0;
        endcase
    end

    assign taken = sel_jalr | sel_jal | (sel_br & cond_taken);

    // Targets wrap modulo 2^XLEN; JALR clears bit 0 of its sum.
    assign sum_pc      = ex_pc_i + ex_imm_i;
    assign sum_rs1     = ex_rs1_data_i + ex_imm_i;
    assign target_next = sel_jalr ? (sum_rs1 & ~XLEN'(1)) : sum_pc;
    assign misaligned  = (target_next[1:0] != 2'b00);

    assign resolve     = ex_valid_i & ~stall_i & (state_reg == IDLE);
    assign do_redirect = resolve & taken & ~misaligned;
    assign do_misalign = resolve & taken & misaligned;
    assign count_br    = resolve & sel_br & ~br_illegal;
    assign count_taken = count_br & cond_taken;

    // Redirect/flush sequencer with registered pulse outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg     <= IDLE;
            flush_cnt_reg <= 4'd0;
            redirect_reg  <= 1'b0;
            misalign_reg  <= 1'b0;
            illegal_reg   <= 1'b0;
            target_reg    <= '0;
        end else begin
            redirect_reg <= do_redirect;
            misalign_reg <= do_misalign;
            illegal_reg  <= resolve & br_illegal;
            case (state_reg)
                IDLE: begin
                    if (do_redirect) begin
                        target_reg    <= target_next;
                        state_reg     <= FLUSH;
                        flush_cnt_reg <= FLUSH_LOAD;
                    end
                end
                FLUSH: begin
                    // A stall freezes the flush so younger stages stay squashed.
                    if (!stall_i) begin
                        flush_cnt_reg <= flush_cnt_reg - 4'd1;
                        if (flush_cnt_reg == 4'd1) begin
                            state_reg <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Saturating performance counters for conditional branches.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            br_cnt_reg    <= '0;
            taken_cnt_reg <= '0;
        end else begin
            if (count_br && (br_cnt_reg != '1)) begin
                br_cnt_reg <= br_cnt_reg + CNT_W'(1);
            end
            if (count_taken && (taken_cnt_reg != '1)) begin
                taken_cnt_reg <= taken_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign redirect_o    = redirect_reg;
    assign pc_target_o   = target_reg;
    assign flush_o       = (state_reg == FLUSH);
    assign misalign_o    = misalign_reg;
    assign illegal_br_o  = illegal_reg;
    assign br_count_o    = br_cnt_reg;
    assign taken_count_o = taken_cnt_reg;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: each driven cycle pushes the
// hand-computed outputs expected after the next edge; a negedge monitor pops
// and compares them.
module tb_branch_resolve_unit;

    localparam int XLEN = 32;
    localparam int CW   = 4;

    logic            clk;
    logic            rst_ni;
    logic            stall;
    logic            ex_valid;
    logic            ex_is_br;
    logic            ex_is_jal;
    logic            ex_is_jalr;
    logic [2:0]      ex_funct3;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_imm;
    logic [XLEN-1:0] ex_rs1;
    logic            br_less;
    logic            br_equal;
    logic            br_unsigned;
    logic            redirect;
    logic [XLEN-1:0] pc_target;
    logic            flush;
    logic            misalign;
    logic            illegal_br;
    logic [CW-1:0]   br_count;
    logic [CW-1:0]   taken_count;

    branch_resolve_unit #(
        .XLEN(XLEN),
        .FLUSH_CYCLES(2),
        .CNT_W(CW)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_ni),
        .stall_i(stall),
        .ex_valid_i(ex_valid),
        .ex_is_br_i(ex_is_br),
        .ex_is_jal_i(ex_is_jal),
        .ex_is_jalr_i(ex_is_jalr),
        .ex_funct3_i(ex_funct3),
        .ex_pc_i(ex_pc),
        .ex_imm_i(ex_imm),
        .ex_rs1_data_i(ex_rs1),
        .br_less_i(br_less),
        .br_equal_i(br_equal),
        .br_unsigned_o(br_unsigned),
        .redirect_o(redirect),
        .pc_target_o(pc_target),
        .flush_o(flush),
        .misalign_o(misalign),
        .illegal_br_o(illegal_br),
        .br_count_o(br_count),
        .taken_count_o(taken_count)
    );

    typedef struct {
        int              cyc;
        string           name;
        logic            red;
        logic            fl;
        logic            mis;
        logic            ill;
        logic [XLEN-1:0] tgt;
        logic [CW-1:0]   bc;
        logic [CW-1:0]   tc;
    } exp_t;

    exp_t sb[$];
    int   cyc     = 0;
    int   n_check = 0;
    int   n_fail  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle index used to tag scoreboard entries.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation due this cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            n_check++;
            if (e.cyc != cyc) begin
                n_fail++;
                $display("FAIL %s: stale entry for cycle %0d, now cycle %0d", e.name, e.cyc, cyc);
            end else if (redirect !== e.red || flush !== e.fl || misalign !== e.mis ||
                         illegal_br !== e.ill || pc_target !== e.tgt ||
                         br_count !== e.bc || taken_count !== e.tc) begin
                n_fail++;
                $display("FAIL %s: got red=%0b fl=%0b mis=%0b ill=%0b tgt=%h bc=%0d tc=%0d, expected red=%0b fl=%0b mis=%0b ill=%0b tgt=%h bc=%0d tc=%0d",
                         e.name, redirect, flush, misalign, illegal_br, pc_target, br_count, taken_count,
                         e.red, e.fl, e.mis, e.ill, e.tgt, e.bc, e.tc);
            end
        end
    end

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_check++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs (called at posedge+1) and queue the outputs expected after the edge.
    task automatic step(input string name, input logic v, input logic st,
                        input logic br, input logic jal, input logic jalr,
                        input logic [2:0] f3, input logic [XLEN-1:0] pc,
                        input logic [XLEN-1:0] imm, input logic [XLEN-1:0] rs1,
                        input logic less, input logic eq, input logic e_uns,
                        input logic e_red, input logic e_fl, input logic e_mis, input logic e_ill,
                        input logic [XLEN-1:0] e_tgt, input logic [CW-1:0] e_bc, input logic [CW-1:0] e_tc);
        exp_t e;
        ex_valid   = v;
        stall      = st;
        ex_is_br   = br;
        ex_is_jal  = jal;
        ex_is_jalr = jalr;
        ex_funct3  = f3;
        ex_pc      = pc;
        ex_imm     = imm;
        ex_rs1     = rs1;
        br_less    = less;
        br_equal   = eq;
        #1;
        chk({name, "_unsigned"}, {31'd0, br_unsigned}, {31'd0, e_uns});
        e.cyc  = cyc + 1;
        e.name = name;
        e.red  = e_red;
        e.fl   = e_fl;
        e.mis  = e_mis;
        e.ill  = e_ill;
        e.tgt  = e_tgt;
        e.bc   = e_bc;
        e.tc   = e_tc;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic nop(input string name, input logic st, input logic e_fl,
                       input logic [XLEN-1:0] e_tgt, input logic [CW-1:0] e_bc, input logic [CW-1:0] e_tc);
        step(name, 1'b0, st, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0,
             1'b0, e_fl, 1'b0, 1'b0, e_tgt, e_bc, e_tc);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_redirect"}, {31'd0, redirect}, 32'd0);
        chk({name, "_flush"}, {31'd0, flush}, 32'd0);
        chk({name, "_misalign"}, {31'd0, misalign}, 32'd0);
        chk({name, "_illegal"}, {31'd0, illegal_br}, 32'd0);
        chk({name, "_target"}, pc_target, 32'd0);
        chk({name, "_br_count"}, {28'd0, br_count}, 32'd0);
        chk({name, "_taken_count"}, {28'd0, taken_count}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [CW-1:0] bcv;
        logic [CW-1:0] tcv;
        rst_ni = 1'b0;
        stall = 1'b0; ex_valid = 1'b0; ex_is_br = 1'b0; ex_is_jal = 1'b0; ex_is_jalr = 1'b0;
        ex_funct3 = 3'b000; ex_pc = '0; ex_imm = '0; ex_rs1 = '0; br_less = 1'b0; br_equal = 1'b0;
        @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_ni = 1'b1;

        // BEQ taken, then two flush cycles.
        step("beq_taken", 1,0, 1,0,0, 3'b000, 32'h100, 32'h20, 32'h0, 0,1, 0,  1,1,0,0, 32'h120, 4'd1, 4'd1);
        nop("beq_flush2", 0, 1, 32'h120, 4'd1, 4'd1);
        nop("beq_flush_end", 0, 0, 32'h120, 4'd1, 4'd1);
        // BLTU not taken.
        step("bltu_nt", 1,0, 1,0,0, 3'b110, 32'h140, 32'h40, 32'h0, 0,0, 1,  0,0,0,0, 32'h120, 4'd2, 4'd1);
        // JALR aligned, then misaligned.
        step("jalr_ok", 1,0, 0,0,1, 3'b000, 32'h180, 32'h4, 32'h1001, 0,0, 0,  1,1,0,0, 32'h1004, 4'd2, 4'd1);
        nop("jalr_flush2", 0, 1, 32'h1004, 4'd2, 4'd1);
        nop("jalr_flush_end", 0, 0, 32'h1004, 4'd2, 4'd1);
        step("jalr_misalign", 1,0, 0,0,1, 3'b000, 32'h180, 32'h0, 32'h1002, 0,0, 0,  0,0,1,0, 32'h1004, 4'd2, 4'd1);
        // Illegal funct3 010.
        step("br_illegal", 1,0, 1,0,0, 3'b010, 32'h1c0, 32'h8, 32'h0, 1,1, 1,  0,0,0,1, 32'h1004, 4'd2, 4'd1);
        // JAL wrap-around.
        step("jal_wrap", 1,0, 0,1,0, 3'b000, 32'hFFFF_FFF0, 32'h20, 32'h0, 0,0, 0,  1,1,0,0, 32'h10, 4'd2, 4'd1);
        nop("jal_flush2", 0, 1, 32'h10, 4'd2, 4'd1);
        nop("jal_flush_end", 0, 0, 32'h10, 4'd2, 4'd1);
        // Taken BNE to a misaligned target: counted, no redirect.
        step("bne_misalign", 1,0, 1,0,0, 3'b001, 32'h200, 32'h6, 32'h0, 0,0, 0,  0,0,1,0, 32'h10, 4'd3, 4'd2);
        // Stalled valid branch in IDLE is not resolved.
        step("stall_idle", 1,1, 1,0,0, 3'b000, 32'h240, 32'h8, 32'h0, 0,1, 0,  0,0,0,0, 32'h10, 4'd3, 4'd2);
        // BLT taken, then stall three cycles in FLUSH with wrong-path branches.
        step("blt_taken", 1,0, 1,0,0, 3'b100, 32'h300, 32'h40, 32'h0, 1,0, 0,  1,1,0,0, 32'h340, 4'd4, 4'd3);
        for (int i = 0; i < 3; i++) begin
            step("flush_stall", 1,1, 1,0,0, 3'b000, 32'h400, 32'h8, 32'h0, 0,1, 0,  0,1,0,0, 32'h340, 4'd4, 4'd3);
        end
        step("flush_wrongpath1", 1,0, 1,0,0, 3'b000, 32'h400, 32'h8, 32'h0, 0,1, 0,  0,1,0,0, 32'h340, 4'd4, 4'd3);
        step("flush_wrongpath2", 1,0, 1,0,0, 3'b000, 32'h404, 32'h8, 32'h0, 0,1, 0,  0,0,0,0, 32'h340, 4'd4, 4'd3);
        // Back-to-back not-taken BNEs.
        step("bne_nt1", 1,0, 1,0,0, 3'b001, 32'h500, 32'h10, 32'h0, 0,1, 0,  0,0,0,0, 32'h340, 4'd5, 4'd3);
        step("bne_nt2", 1,0, 1,0,0, 3'b001, 32'h504, 32'h10, 32'h0, 0,1, 0,  0,0,0,0, 32'h340, 4'd6, 4'd3);
        // 17 taken BNEs saturate both 4-bit counters at 15.
        for (int i = 0; i < 17; i++) begin
            bcv = (6 + i + 1 > 15) ? 4'd15 : CW'(6 + i + 1);
            tcv = (3 + i + 1 > 15) ? 4'd15 : CW'(3 + i + 1);
            step("bne_sat", 1,0, 1,0,0, 3'b001, 32'h500, 32'h10, 32'h0, 0,0, 0,  1,1,0,0, 32'h510, bcv, tcv);
            nop("bne_sat_flush2", 0, 1, 32'h510, bcv, tcv);
            nop("bne_sat_flush_end", 0, 0, 32'h510, bcv, tcv);
        end
        // Enter FLUSH, then assert reset mid-flush.
        step("bne_pre_reset", 1,0, 1,0,0, 3'b001, 32'h600, 32'h0, 32'h0, 0,0, 0,  1,1,0,0, 32'h600, 4'd15, 4'd15);
        #5;
        rst_ni = 1'b0;
        #1;
        chk_all_zero("reset_midflush");
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        nop("post_reset", 0, 0, 32'h0, 4'd0, 4'd0);
        step("beq_after_reset", 1,0, 1,0,0, 3'b000, 32'h100, 32'h20, 32'h0, 0,1, 0,  1,1,0,0, 32'h120, 4'd1, 4'd1);
        nop("final_flush2", 0, 1, 32'h120, 4'd1, 4'd1);
        nop("final_flush_end", 0, 0, 32'h120, 4'd1, 4'd1);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
        $finish;
    end

endmodule
